usrprj_out_packer: RTL and testbench

Downstream stage of the user-project FFT/NTT engine: consumes its master AXI-Stream result output (x/y word pairs in F mode, 16-bit samples in U mode). Emits a packed 32-bit AXI-Stream toward the FSIC return path.
- U-mode samples are packed two per word, halving return-path bandwidth.
- Frame length is checked against the mode, and a frame-done flag, beat count and optional XOR checksum are exposed.

---
 rtl/usrprj_out_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_usrprj_out_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/usrprj_out_packer.sv
// Packs FFT/NTT engine results into a 32-bit AXI-Stream: F words pass through, U samples go two per word.
// Optional XOR checksum of emitted words is enabled by defining USRPRJ_OUTPACK_CHKSUM_EN.
module usrprj_out_packer #(
   parameter int pDATA_WIDTH = 32,
   parameter int pCNT_WIDTH  = 12
) (
   input  logic                   axi_clk,
   input  logic                   axi_rst,
   input  logic [1:0]             mode,
   input  logic                   start,
   input  logic                   in_tvalid,
   input  logic [pDATA_WIDTH-1:0] in_tdata,
   input  logic                   in_tlast,
   output logic                   in_tready,
   output logic                   out_tvalid,
   output logic [pDATA_WIDTH-1:0] out_tdata,
   output logic                   out_tlast,
   input  logic                   out_tready,
   output logic                   done,
   output logic                   err_len,
   output logic [pCNT_WIDTH-1:0]  beat_cnt,
   output logic [31:0]            chksum
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [pCNT_WIDTH-1:0] F_LEN = pCNT_WIDTH'(32'd2048);
   localparam logic [pCNT_WIDTH-1:0] U_LEN = pCNT_WIDTH'(32'd1024);

   state_t                   state_q, state_d;
   logic                     umode_q, umode_d;
   logic                     phase_q, phase_d;
   logic [15:0]              half_q, half_d;
   logic [pCNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     done_q, done_d;
   logic                     rdy_q, rdy_d;
   logic                     vld_q, vld_d;
   logic [1:0]               bcnt_q, bcnt_d;
   logic [pDATA_WIDTH-1:0]   e0_data_q, e0_data_d, e1_data_q, e1_data_d;
   logic                     e0_last_q, e0_last_d, e1_last_q, e1_last_d;
   logic [31:0]              chk_q, chk_d;

   logic                     accept_s, pop_s, push_s, push_last_s, end_s;
   logic [pDATA_WIDTH-1:0]   push_data_s;
   logic [pCNT_WIDTH-1:0]    exp_len_s, cnt_inc_s;

   // Next-state logic for frame FSM, U-mode pairing and the two-entry skid buffer
   always_comb begin
      state_d     = state_q;
      umode_d     = umode_q;
      phase_d     = phase_q;
      half_d      = half_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      e0_data_d   = e0_data_q;
      e0_last_d   = e0_last_q;
      e1_data_d   = e1_data_q;
      e1_last_d   = e1_last_q;
      bcnt_d      = bcnt_q;
      chk_d       = chk_q;
      push_s      = 1'b0;
      push_last_s = 1'b0;
      push_data_s = '0;
      end_s       = 1'b0;
      accept_s    = in_tvalid && rdy_q;
      pop_s       = vld_q && out_tready;
      exp_len_s   = umode_q ? U_LEN : F_LEN;
      cnt_inc_s   = cnt_q + pCNT_WIDTH'(32'd1);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               umode_d = mode[1];
               phase_d = 1'b0;
               half_d  = 16'h0000;
               cnt_d   = '0;
               err_d   = 1'b0;
               chk_d   = 32'h0000_0000;
            end else begin
               state_d = state_q;
            end
         end
         S_RUN: begin
            if (accept_s) begin
               cnt_d = (cnt_q == exp_len_s) ? cnt_q : cnt_inc_s;
               end_s = in_tlast || (cnt_inc_s == exp_len_s);
               if (in_tlast ^ (cnt_inc_s == exp_len_s)) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               // An even U sample that ends the frame is emitted alone, zero-padded above
               if (!umode_q) begin
                  push_s      = 1'b1;
                  push_data_s = in_tdata;
                  push_last_s = end_s;
               end else if (phase_q) begin
                  push_s      = 1'b1;
                  push_data_s = {in_tdata[15:0], half_q};
                  push_last_s = end_s;
                  phase_d     = 1'b0;
               end else if (end_s) begin
                  push_s      = 1'b1;
                  push_data_s = {16'h0000, in_tdata[15:0]};
                  push_last_s = 1'b1;
               end else begin
                  half_d  = in_tdata[15:0];
                  phase_d = 1'b1;
               end
               if (end_s) begin
                  state_d = S_FLUSH;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            if (pop_s && e0_last_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      case ({push_s, pop_s})
         2'b10: begin
            if (bcnt_q == 2'd0) begin
               e0_data_d = push_data_s;
               e0_last_d = push_last_s;
            end else begin
               e1_data_d = push_data_s;
               e1_last_d = push_last_s;
            end
            bcnt_d = bcnt_q + 2'd1;
         end
         2'b01: begin
            e0_data_d = e1_data_q;
            e0_last_d = e1_last_q;
            bcnt_d    = bcnt_q - 2'd1;
         end
         2'b11: begin
            if (bcnt_q == 2'd1) begin
               e0_data_d = push_data_s;
               e0_last_d = push_last_s;
            end else begin
               e0_data_d = e1_data_q;
               e0_last_d = e1_last_q;
               e1_data_d = push_data_s;
               e1_last_d = push_last_s;
            end
         end
         default: bcnt_d = bcnt_q;
      endcase

      if (pop_s) begin
         chk_d = chk_d ^ 32'(e0_data_q);
      end else begin
         chk_d = chk_d;
      end

      // Ready looks at next-cycle occupancy so out_tready never reaches in_tready combinationally
      rdy_d  = (state_d == S_RUN) && (bcnt_d != 2'd2);
      vld_d  = (bcnt_d != 2'd0);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset drops any buffered data
   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         state_q   <= S_IDLE;
         umode_q   <= 1'b0;
         phase_q   <= 1'b0;
         half_q    <= 16'h0000;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
         vld_q     <= 1'b0;
         bcnt_q    <= 2'd0;
         e0_data_q <= '0;
         e0_last_q <= 1'b0;
         e1_data_q <= '0;
         e1_last_q <= 1'b0;
         chk_q     <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         umode_q   <= umode_d;
         phase_q   <= phase_d;
         half_q    <= half_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
         rdy_q     <= rdy_d;
         vld_q     <= vld_d;
         bcnt_q    <= bcnt_d;
         e0_data_q <= e0_data_d;
         e0_last_q <= e0_last_d;
         e1_data_q <= e1_data_d;
         e1_last_q <= e1_last_d;
         chk_q     <= chk_d;
      end
   end

   assign in_tready  = rdy_q;
   assign out_tvalid = vld_q;
   assign out_tdata  = vld_q ? e0_data_q : '0;
   assign out_tlast  = vld_q && e0_last_q;
   assign done       = done_q;
   assign err_len    = err_q;
   assign beat_cnt   = cnt_q;
`ifdef USRPRJ_OUTPACK_CHKSUM_EN
   assign chksum     = chk_q;
`else
   assign chksum     = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_usrprj_out_packer.sv
// Directed bench for usrprj_out_packer: table of frame scenarios plus reset and latency sequences.
module tb_usrprj_out_packer;

   logic        axi_clk = 1'b0;
   logic        axi_rst;
   logic [1:0]  mode;
   logic        start;
   logic        in_tvalid;
   logic [31:0] in_tdata;
   logic        in_tlast;
   logic        in_tready;
   logic        out_tvalid;
   logic [31:0] out_tdata;
   logic        out_tlast;
   logic        out_tready;
   logic        done;
   logic        err_len;
   logic [11:0] beat_cnt;
   logic [31:0] chksum;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  mode;
      int          nsamp;
      int          tlast_idx;
      logic [15:0] upper;
      bit          stall;
      bit          gaps;
      int          exp_words;
      bit          exp_err;
      logic [31:0] exp_last;
   } vec_t;

   vec_t vecs[7];

   usrprj_out_packer dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst), .mode(mode), .start(start),
      .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tready(out_tready),
      .done(done), .err_len(err_len), .beat_cnt(beat_cnt), .chksum(chksum)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input bit u, input int k, input int n_eff);
      if (!u) return 32'(k);
      if (2 * k + 1 < n_eff) return {16'(2 * k + 1), 16'(2 * k)};
      return {16'h0000, 16'(2 * k)};
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_tready"}, 32'(in_tready), 32'd0);
      chk({tag, "_out_tvalid"}, 32'(out_tvalid), 32'd0);
      chk({tag, "_out_tdata"}, out_tdata, 32'd0);
      chk({tag, "_out_tlast"}, 32'(out_tlast), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err_len"}, 32'(err_len), 32'd0);
      chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
      chk({tag, "_chksum"}, chksum, 32'd0);
   endtask

   task automatic run_frame(input vec_t v);
      int          e_len, n_eff, nw, sent, got, used;
      bit          u, exp_err, finished, done_pending, prev_stall, plast;
      logic [31:0] pdata, lastw, xm;
      u       = v.mode[1];
      e_len   = u ? 1024 : 2048;
      n_eff   = (v.tlast_idx >= 0 && v.tlast_idx + 1 <= e_len) ? v.tlast_idx + 1 : e_len;
      exp_err = (v.tlast_idx != e_len - 1);
      nw      = u ? (n_eff + 1) / 2 : n_eff;
      xm      = 32'd0;
      for (int k = 0; k < nw; k++) xm ^= exp_word(u, k, n_eff);
      sent = 0; got = 0; used = 0; lastw = 32'd0;
      finished = 0; done_pending = 0; prev_stall = 0; pdata = 32'd0; plast = 0;

      @(negedge axi_clk);
      mode  = v.mode;
      start = 1'b1;
      @(negedge axi_clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_tvalid), 32'd1);
            chk("stall_data", out_tdata, pdata);
            chk("stall_last", 32'(out_tlast), 32'(plast));
         end
         if (done_pending) begin
            chk("done_timing", 32'(done), 32'd1);
            finished = 1;
            used = cyc;
            break;
         end
         in_tvalid  = (sent < v.nsamp) && (!v.gaps || $urandom_range(0, 1) == 1);
         in_tdata   = u ? {v.upper, 16'(sent)} : 32'(sent);
         in_tlast   = (sent == v.tlast_idx);
         out_tready = v.stall ? cyc[0] : 1'b1;
         if (in_tvalid && in_tready) sent++;
         if (out_tvalid && out_tready) begin
            chk("word_data", out_tdata, exp_word(u, got, n_eff));
            chk("word_last", 32'(out_tlast), 32'(got == nw - 1));
            if (out_tlast) begin
               done_pending = 1;
               lastw = out_tdata;
            end
            got++;
         end
         prev_stall = out_tvalid && !out_tready;
         pdata      = out_tdata;
         plast      = out_tlast;
         @(negedge axi_clk);
      end
      in_tvalid  = 1'b0;
      in_tlast   = 1'b0;
      out_tready = 1'b1;
      if (!finished) chk("frame_timeout", 32'd0, 32'd1);
      chk("word_count", 32'(got), 32'(v.exp_words));
      chk("last_word", lastw, v.exp_last);
      chk("beats_sent", 32'(sent), 32'(n_eff));
      chk("err_len", 32'(err_len), 32'(v.exp_err));
      chk("err_model", 32'(err_len), 32'(exp_err));
      chk("beat_cnt", 32'(beat_cnt), 32'(n_eff));
      chk("ready_after", 32'(in_tready), 32'd0);
`ifdef USRPRJ_OUTPACK_CHKSUM_EN
      chk("chksum", chksum, xm);
`else
      chk("chksum", chksum, 32'd0);
`endif
      if (!v.stall && !v.gaps) chk("throughput", 32'(used <= n_eff + 8), 32'd1);
   endtask

   initial begin
      int sent;
      bit first;
      vecs[0] = '{2'd0, 2048, 2047, 16'h0000, 1'b0, 1'b0, 2048, 1'b0, 32'd2047};
      vecs[1] = '{2'd2, 1024, 1023, 16'hFFFF, 1'b0, 1'b0, 512, 1'b0, 32'h03FF_03FE};
      vecs[2] = '{2'd1, 300, 299, 16'h0000, 1'b1, 1'b1, 300, 1'b1, 32'd299};
      vecs[3] = '{2'd3, 7, 6, 16'hFFFF, 1'b0, 1'b0, 4, 1'b1, 32'h0000_0006};
      vecs[4] = '{2'd0, 2100, -1, 16'h0000, 1'b0, 1'b0, 2048, 1'b1, 32'd2047};
      vecs[5] = '{2'd2, 9, 8, 16'h1234, 1'b1, 1'b0, 5, 1'b1, 32'h0000_0008};
      vecs[6] = '{2'd2, 6, 5, 16'h0000, 1'b0, 1'b1, 3, 1'b1, 32'h0005_0004};

      axi_rst = 1'b1; mode = 2'd0; start = 1'b0;
      in_tvalid = 1'b0; in_tdata = 32'd0; in_tlast = 1'b0; out_tready = 1'b1;
      @(negedge axi_clk);
      @(negedge axi_clk);
      check_all_zero("reset");
      axi_rst = 1'b0;

      for (int i = 0; i < 7; i++) run_frame(vecs[i]);

      // Mid-frame reset: run 100 beats of an F frame, checking first-beat latency on the way
      @(negedge axi_clk);
      mode = 2'd0; start = 1'b1;
      @(negedge axi_clk);
      start = 1'b0; sent = 0; first = 1;
      for (int c = 0; c < 400 && sent < 100; c++) begin
         if (sent == 1 && first) begin
            chk("lat_valid", 32'(out_tvalid), 32'd1);
            chk("lat_data", out_tdata, 32'd0);
            chk("bcnt_first", 32'(beat_cnt), 32'd1);
            first = 0;
         end
         in_tvalid = 1'b1; in_tdata = 32'(sent); in_tlast = 1'b0; out_tready = 1'b1;
         if (in_tready) sent++;
         @(negedge axi_clk);
      end
      chk("rst_reach", 32'(sent), 32'd100);
      chk("rst_bcnt_pre", 32'(beat_cnt), 32'd100);
      in_tvalid = 1'b0;
      axi_rst = 1'b1;
      #1;
      check_all_zero("rst_async");
      @(negedge axi_clk);
      check_all_zero("rst_next");
      axi_rst = 1'b0;
      @(negedge axi_clk);
      check_all_zero("rst_after");
      run_frame(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
